// File: rtl/a2d_sched.sv
// rtl/a2d_sched.sv - round-robin scheduler for four A2D conversions over the SPI master handshake
// Each conversion is a channel-select transaction followed by a read transaction with the same command word.
module a2d_sched #(
  parameter int PERIOD   = 1024,
  parameter bit FAST_SIM = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        rnd_vld
);

  localparam int P  = FAST_SIM ? 16 : PERIOD;
  localparam int CW = (P > 2) ? $clog2(P) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(P - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WAIT1,
    GAP,
    READ,
    WAIT2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [1:0]      idx_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      chnl;
  logic            load;

  always_comb begin
    case (idx_q)
      2'd0:    chnl = 3'd0;
      2'd1:    chnl = 3'd4;
      2'd2:    chnl = 3'd5;
      default: chnl = 3'd6;
    endcase
  end

  assign cmd = {2'b00, chnl, 11'h000};

  always_comb begin
    state_d = state_q;
    wrt     = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        // The rnd_vld cycle does not count toward the idle period.
        if (!rnd_vld && (cnt_q == CNT_LAST)) state_d = CMD;
      end
      CMD: begin
        wrt     = 1'b1;
        state_d = WAIT1;
      end
      WAIT1: begin
        if (done) state_d = GAP;
      end
      GAP: begin
        state_d = READ;
      end
      READ: begin
        wrt     = 1'b1;
        state_d = WAIT2;
      end
      WAIT2: begin
        if (done) begin
          load    = 1'b1;
          state_d = (idx_q == 2'd3) ? IDLE : CMD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      cnt_q     <= '0;
      rnd_vld   <= 1'b0;
      lft_ld    <= 12'h000;
      rght_ld   <= 12'h000;
      steer_pot <= 12'h000;
      batt      <= 12'h000;
    end else begin
      state_q <= state_d;
      rnd_vld <= load && (idx_q == 2'd3);

      if ((state_q == IDLE) && (state_d == IDLE) && !rnd_vld)
        cnt_q <= cnt_q + 1'b1;
      else
        cnt_q <= '0;

      // Index wraps 3 -> 0 at the end of a round.
      if (state_q == IDLE)
        idx_q <= 2'd0;
      else if (load)
        idx_q <= idx_q + 2'd1;

      if (load) begin
        case (idx_q)
          2'd0:    lft_ld    <= rd_data[11:0];
          2'd1:    rght_ld   <= rd_data[11:0];
          2'd2:    steer_pot <= rd_data[11:0];
          default: batt      <= rd_data[11:0];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_a2d_sched.sv
// tb/tb_a2d_sched.sv - directed bench for a2d_sched with an inline SPI responder
// A second instance with FAST_SIM=0, PERIOD=40 covers the long idle period.
module tb_a2d_sched;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, done, wrt, rnd_vld;
  logic [15:0] rd_data, cmd;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;

  logic        rst_p, done_p, wrt_p, rnd_vld_p;
  logic [15:0] rd_data_p, cmd_p;
  logic [11:0] lft_ld_p, rght_ld_p, steer_pot_p, batt_p;

  int vectors     = 0;
  int miscompares = 0;

  logic [11:0] exp_reg [4];
  logic [2:0]  ch_tab  [4] = '{3'd0, 3'd4, 3'd5, 3'd6};

  a2d_sched #(.PERIOD(1024), .FAST_SIM(1'b1)) dut (
    .clk(clk), .rst(rst), .wrt(wrt), .cmd(cmd), .done(done), .rd_data(rd_data),
    .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt),
    .rnd_vld(rnd_vld)
  );

  a2d_sched #(.PERIOD(40), .FAST_SIM(1'b0)) dut_p (
    .clk(clk), .rst(rst_p), .wrt(wrt_p), .cmd(cmd_p), .done(done_p), .rd_data(rd_data_p),
    .lft_ld(lft_ld_p), .rght_ld(rght_ld_p), .steer_pot(steer_pot_p), .batt(batt_p),
    .rnd_vld(rnd_vld_p)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_lft"},   {20'h0, lft_ld},    {20'h0, exp_reg[0]});
    chk({tag, "_rght"},  {20'h0, rght_ld},   {20'h0, exp_reg[1]});
    chk({tag, "_steer"}, {20'h0, steer_pot}, {20'h0, exp_reg[2]});
    chk({tag, "_batt"},  {20'h0, batt},      {20'h0, exp_reg[3]});
  endtask

  task automatic wait_wrt(output int n);
    n = 0;
    while (wrt !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  // One SPI transaction: done returned 10 cycles after wrt.
  task automatic xact(input int idx, input logic [11:0] data, input bit second, input bit spur_cmd);
    int n;
    wait_wrt(n);
    chk("wrt_seen", {31'h0, wrt}, 32'h1);
    chk("cmd_chnl", {16'h0, cmd}, {16'h0, 2'b00, ch_tab[idx], 11'h000});
    if (spur_cmd) begin
      done    = 1'b1;
      rd_data = 16'h0EEE;
    end
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      done = 1'b0;
      chk("wrt_low_in_wait", {31'h0, wrt}, 32'h0);
    end
    done    = 1'b1;
    rd_data = {4'hF, data};
    @(negedge clk);
    done = 1'b0;
    if (second) exp_reg[idx] = data;
    chk_regs("regs_after_done");
    if (second && idx == 3) begin
      chk("rnd_vld_pulse", {31'h0, rnd_vld}, 32'h1);
      chk("wrt_after_round", {31'h0, wrt}, 32'h0);
    end else if (second) begin
      chk("rnd_vld_mid", {31'h0, rnd_vld}, 32'h0);
      chk("next_chan_wrt", {31'h0, wrt}, 32'h1);
    end else begin
      chk("gap_wrt_low", {31'h0, wrt}, 32'h0);
      chk("rnd_vld_gap", {31'h0, rnd_vld}, 32'h0);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; done = 1'b0; rd_data = 16'h0;
    rst_p = 1'b1; done_p = 1'b0; rd_data_p = 16'h0;
    for (int i = 0; i < 4; i++) exp_reg[i] = 12'h000;

    // Reset state and first-wrt latency
    repeat (2) @(negedge clk);
    chk("rst_wrt", {31'h0, wrt}, 32'h0);
    chk("rst_cmd", {16'h0, cmd}, 32'h0);
    chk("rst_rnd_vld", {31'h0, rnd_vld}, 32'h0);
    chk_regs("rst");
    rst = 1'b0;
    wait_wrt(n);
    chk("first_wrt_delay", n, 16);

    // Full round, channels 0,0,4,4,5,5,6,6
    for (int i = 0; i < 4; i++) begin
      xact(i, 12'h100 + 12'(ch_tab[i]), 1'b0, 1'b0);
      xact(i, 12'h100 + 12'(ch_tab[i]), 1'b1, 1'b0);
    end
    @(negedge clk);
    chk("rnd_vld_one_cycle", {31'h0, rnd_vld}, 32'h0);

    // Discarded first response; also checks round spacing
    wait_wrt(n);
    chk("round_spacing", n + 1, 17);
    for (int i = 0; i < 4; i++) begin
      xact(i, 12'hABC, 1'b0, 1'b0);
      xact(i, 12'h123, 1'b1, 1'b0);
    end

    // Spurious done in IDLE, CMD and GAP
    @(negedge clk);
    done = 1'b1; rd_data = 16'hFFFF;
    @(negedge clk);
    done = 1'b0;
    chk_regs("idle_spur");
    wait_wrt(n);
    chk("idle_spur_spacing", n + 2, 17);
    xact(0, 12'h200, 1'b0, 1'b1);
    done = 1'b1; rd_data = 16'hFEEE;
    @(negedge clk);
    done = 1'b0;
    chk("gap_spur_read", {31'h0, wrt}, 32'h1);
    chk_regs("gap_spur");
    xact(0, 12'h200, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      xact(i, 12'h200 + 12'(i), 1'b0, 1'b0);
      xact(i, 12'h200 + 12'(i), 1'b1, 1'b0);
    end

    // Reset during WAIT2 of channel 5
    xact(0, 12'h400, 1'b0, 1'b0);
    xact(0, 12'h400, 1'b1, 1'b0);
    xact(1, 12'h401, 1'b0, 1'b0);
    xact(1, 12'h401, 1'b1, 1'b0);
    xact(2, 12'h402, 1'b0, 1'b0);
    wait_wrt(n);
    chk("mid_read_cmd", {16'h0, cmd}, {16'h0, 2'b00, 3'd5, 11'h000});
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) exp_reg[i] = 12'h000;
    chk_regs("mid_rst");
    chk("mid_rst_wrt", {31'h0, wrt}, 32'h0);
    chk("mid_rst_cmd", {16'h0, cmd}, 32'h0);
    chk("mid_rst_rnd_vld", {31'h0, rnd_vld}, 32'h0);
    done = 1'b1; rd_data = 16'h0777;
    @(negedge clk);
    done = 1'b0;
    wait_wrt(n);
    chk("post_rst_wrt_delay", n + 1, 16);
    chk("post_rst_cmd", {16'h0, cmd}, 32'h0);
    chk_regs("late_done");

    // Long period instance: PERIOD=40
    rst_p = 1'b0;
    n = 0;
    while (wrt_p !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("p_first_wrt_delay", n, 40);
    for (int k = 0; k < 8; k++) begin
      n = 0;
      while (wrt_p !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("p_cmd_chnl", {16'h0, cmd_p}, {16'h0, 2'b00, ch_tab[k / 2], 11'h000});
      repeat (10) @(negedge clk);
      done_p = 1'b1;
      rd_data_p = 16'h0500 + 16'(k);
      @(negedge clk);
      done_p = 1'b0;
    end
    chk("p_rnd_vld", {31'h0, rnd_vld_p}, 32'h1);
    chk("p_lft", {20'h0, lft_ld_p}, 32'h501);
    chk("p_batt", {20'h0, batt_p}, 32'h507);
    n = 0;
    while (wrt_p !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("p_round_spacing", n, 41);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/a2d_sched.md
# a2d_sched

Round-robin conversion scheduler for the board's 8-channel SPI A2D. It periodically sequences four conversions through the existing SPI master handshake: left load cell, right load cell, steering pot and battery. It holds each 12-bit result in an output register. Its `lft_ld`/`rght_ld` outputs feed the steering-enable logic; `steer_pot` and `batt` feed the balance controller and battery monitor.

## Interface
Parameters:
- `PERIOD`, 1024 — idle cycles between rounds when `FAST_SIM`=0.
- `FAST_SIM`, 1 — when 1, the effective idle period is 16 cycles.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wrt`  out  1  one-cycle pulse that starts an SPI transaction.
- `cmd`  out  16  SPI command word `{2'b00, chnl[2:0], 11'h000}`.
- `done`  in  1  one-cycle pulse from the SPI master when a transaction completes.
- `rd_data`  in  16  SPI receive data, valid in the `done` cycle; only `[11:0]` is used.
- `lft_ld`  out  12  latest left load-cell result.
- `rght_ld`  out  12  latest right load-cell result.
- `steer_pot`  out  12  latest steering-pot result.
- `batt`  out  12  latest battery result.
- `rnd_vld`  out  1  one-cycle pulse when a full round of four results has been updated.

## Operation
- Channel order, by index 0..3 → A2D channel: 0→0 (`lft_ld`), 1→4 (`rght_ld`), 2→5 (`steer_pot`), 3→6 (`batt`).
- Each conversion is two SPI transactions:
  - the first selects the channel (its response is discarded);
  - the second returns the conversion; both send the same `cmd`.
- States:
  - `IDLE`: idle counter increments each cycle. When it reaches P−1 (P = `FAST_SIM` ? 16 : `PERIOD`), set index=0, clear the counter, go to `CMD`.
  - `CMD`: `wrt`=1 for this cycle only → `WAIT1`.
  - `WAIT1`: wait for `done` → `GAP`.
  - `GAP`: one dead cycle, `wrt`=0 → `READ`.
  - `READ`: `wrt`=1 for one cycle → `WAIT2`.
  - `WAIT2`: on `done`, load `rd_data[11:0]` into the register selected by index.
    - If index<3: increment index → `CMD`.
    - If index==3: pulse `rnd_vld`, clear index → `IDLE`.
- `cmd` is driven from index in every state and is stable from `CMD` through the end of `WAIT2`.
- `done` is ignored in every state except `WAIT1`/`WAIT2`, including a `done` coincident with `wrt`.
- No timeout: a missing `done` holds the block in its wait state indefinitely.
- The idle counter runs only in `IDLE` and is sized for `PERIOD`, with no wrap inside a period.
- Result registers change only on a `WAIT2` `done`. Outputs hold their previous values during a round.

## Timing
- Reset values:
  - state `IDLE`, index 0, idle counter 0;
  - `wrt`=0, `cmd`=16'h0000 (channel 0), `rnd_vld`=0;
  - `lft_ld`=`rght_ld`=`steer_pot`=`batt`=12'h000.
- First `wrt` comes P cycles after `rst` deasserts; `IDLE` is occupied for cycles 0..P−1.
- `done` in `WAIT1` at cycle t:
  - `GAP` at t+1;
  - `wrt` high at t+2.
- `done` in `WAIT2` at cycle t:
  - the result register shows the new value at t+1;
  - next channel's `wrt` at t+1 (index<3);
  - or `rnd_vld`=1 at t+1, in the same cycle `batt` updates (index==3).
- `wrt` is never high in two consecutive cycles.
- Round-to-round spacing: the next round's first `wrt` comes P+1 cycles after the `rnd_vld` cycle.
- `rst` asserted mid-round, at any state:
  - the next cycle equals the reset state;
  - a pending SPI transaction's later `done` is ignored (arrives in `IDLE`);
  - partially updated registers are cleared.

## Test plan
- Reset check: assert `rst` 2 cycles → all outputs equal their reset values; the first `wrt` appears exactly 16 cycles after release (`FAST_SIM`=1).
- Full round: SPI model returns `done` 10 cycles after each `wrt`, `rd_data`=`{4'hF, 12'h100+chnl}` → `cmd` channels seen in order 0,0,4,4,5,5,6,6; `lft_ld`=12'h100, `rght_ld`=12'h104, `steer_pot`=12'h105, `batt`=12'h106; `rnd_vld` pulses once, coincident with the `batt` update.
- Discarded first response: return 12'hABC on first transactions and 12'h123 on second → all registers 12'h123, never 12'hABC.
- Spurious `done`: pulse `done` in `IDLE`, `GAP` and the `CMD` cycle → no state change and no register update.
- Reset mid-`WAIT2` of channel 5 (after `lft_ld`/`rght_ld` loaded) → all registers 0 next cycle; a late `done` is ignored; the next round starts 16 cycles later at channel 0.
- Period: `FAST_SIM`=0, `PERIOD`=40 → first `wrt` at cycle 40 after reset; second round's first `wrt` 41 cycles after the first `rnd_vld`.
